// File: rtl/mcu_csr_axil_pkg.sv
//------------------------------------------------------------------------------
// mcu_csr_axil_pkg -- register map, status bit indices and AXI response codes
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mcu_csr_axil_pkg;

  localparam logic [7:0] CSR_CTRL      = 8'h00;
  localparam logic [7:0] CSR_STATUS    = 8'h04;
  localparam logic [7:0] CSR_IRQ_EN    = 8'h08;
  localparam logic [7:0] CSR_DATA_LO   = 8'h10;
  localparam logic [7:0] CSR_DATA_HI   = 8'h14;
  localparam logic [7:0] CSR_GRID_LO   = 8'h18;
  localparam logic [7:0] CSR_GRID_HI   = 8'h1C;
  localparam logic [7:0] CSR_SCLE_LO   = 8'h20;
  localparam logic [7:0] CSR_SCLE_HI   = 8'h24;
  localparam logic [7:0] CSR_RUN_COUNT = 8'h28;

  localparam int ST_BUSY   = 0;
  localparam int ST_DONE   = 1;
  localparam int ST_ERROR  = 2;
  localparam int ST_REJECT = 3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Byte-strobed update of either 32-bit half of a size register.
  function automatic logic [63:0] merge_half(input logic [63:0] cur, input logic hi,
                                             input logic [31:0] data, input logic [3:0] strb);
    logic [63:0] res;
    res = cur;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) begin
        if (hi) res[32 + 8*b +: 8] = data[8*b +: 8];
        else    res[8*b +: 8]      = data[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axil_csr_if.sv
//------------------------------------------------------------------------------
// axil_csr_if -- AXI-lite slave handshake turning bus traffic into register strobes
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module axil_csr_if
  import mcu_csr_axil_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] awaddr_i,
  input  logic              awvalid_i,
  output logic              awready_o,
  input  logic [31:0]       wdata_i,
  input  logic [3:0]        wstrb_i,
  input  logic              wvalid_i,
  output logic              wready_o,
  output logic [1:0]        bresp_o,
  output logic              bvalid_o,
  input  logic              bready_i,
  input  logic [ADDR_W-1:0] araddr_i,
  input  logic              arvalid_i,
  output logic              arready_o,
  output logic [31:0]       rdata_o,
  output logic [1:0]        rresp_o,
  output logic              rvalid_o,
  input  logic              rready_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [31:0]       wr_data_o,
  output logic [3:0]        wr_strb_o,
  input  logic              wr_err_i,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [31:0]       rd_data_i,
  input  logic              rd_err_i
);

  logic              aw_full_q, w_full_q, bvalid_q, rvalid_q;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [31:0]       w_data_q, rdata_q;
  logic [3:0]        w_strb_q;
  logic [1:0]        bresp_q, rresp_q;
  logic              aw_hs, w_hs;

  // Readies are forced low while reset is asserted, not just after it releases.
  assign awready_o = !rst && !aw_full_q && !bvalid_q;
  assign wready_o  = !rst && !w_full_q  && !bvalid_q;
  assign arready_o = !rst && !rvalid_q;

  assign aw_hs = awvalid_i && awready_o;
  assign w_hs  = wvalid_i  && wready_o;

  // A channel arriving this cycle counts as held, so AW+W together complete in one cycle.
  assign wr_en_o   = (aw_full_q || aw_hs) && (w_full_q || w_hs);
  assign wr_addr_o = aw_full_q ? aw_addr_q : awaddr_i;
  assign wr_data_o = w_full_q  ? w_data_q  : wdata_i;
  assign wr_strb_o = w_full_q  ? w_strb_q  : wstrb_i;

  assign rd_en_o   = arvalid_i && arready_o;
  assign rd_addr_o = araddr_i;

  assign bvalid_o = bvalid_q;
  assign bresp_o  = bresp_q;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign rresp_o  = rresp_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else if (wr_en_o) begin
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      bvalid_q  <= 1'b1;
      bresp_q   <= wr_err_i ? RESP_SLVERR : RESP_OKAY;
    end else begin
      if (aw_hs) begin
        aw_full_q <= 1'b1;
        aw_addr_q <= awaddr_i;
      end
      if (w_hs) begin
        w_full_q <= 1'b1;
        w_data_q <= wdata_i;
        w_strb_q <= wstrb_i;
      end
      if (bvalid_q && bready_i) bvalid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (rd_en_o) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_data_i;
      rresp_q  <= rd_err_i ? RESP_SLVERR : RESP_OKAY;
    end else if (rvalid_q && rready_i) begin
      rvalid_q <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mcu_csr_axil.sv
//------------------------------------------------------------------------------
// mcu_csr_axil -- MCU control/status register file: sizes, start pulse, status, irq
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mcu_csr_axil
  import mcu_csr_axil_pkg::*;
#(
  parameter int ADDR_WIDTH_DATA  = 32,
  parameter int ADDR_WIDTH_GRID  = 32,
  parameter int ADDR_WIDTH_SCALE = 32,
  parameter int AXIL_ADDR_WIDTH  = 6
) (
  input  logic                       fsm_clk,
  input  logic                       rst,
  input  logic [AXIL_ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]                 s_axil_awprot,
  input  logic                       s_axil_awvalid,
  output logic                       s_axil_awready,
  input  logic [31:0]                s_axil_wdata,
  input  logic [3:0]                 s_axil_wstrb,
  input  logic                       s_axil_wvalid,
  output logic                       s_axil_wready,
  output logic [1:0]                 s_axil_bresp,
  output logic                       s_axil_bvalid,
  input  logic                       s_axil_bready,
  input  logic [AXIL_ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]                 s_axil_arprot,
  input  logic                       s_axil_arvalid,
  output logic                       s_axil_arready,
  output logic [31:0]                s_axil_rdata,
  output logic [1:0]                 s_axil_rresp,
  output logic                       s_axil_rvalid,
  input  logic                       s_axil_rready,
  output logic                       operation_start,
  output logic [ADDR_WIDTH_DATA:0]   data_size,
  output logic [ADDR_WIDTH_GRID:0]   grid_size,
  output logic [ADDR_WIDTH_SCALE:0]  scle_size,
  input  logic                       operation_busy,
  input  logic                       operation_complete,
  input  logic                       operation_error,
  output logic                       irq
);

  localparam int DW = ADDR_WIDTH_DATA + 1;
  localparam int GW = ADDR_WIDTH_GRID + 1;
  localparam int SW = ADDR_WIDTH_SCALE + 1;

  logic                       wr_en, wr_err, rd_en_unused, rd_err;
  logic [AXIL_ADDR_WIDTH-1:0] wr_addr, rd_addr;
  logic [31:0]                wr_data, rd_data;
  logic [3:0]                 wr_strb;

  axil_csr_if #(.ADDR_W(AXIL_ADDR_WIDTH)) u_if (
    .clk(fsm_clk), .rst(rst),
    .awaddr_i(s_axil_awaddr), .awvalid_i(s_axil_awvalid), .awready_o(s_axil_awready),
    .wdata_i(s_axil_wdata), .wstrb_i(s_axil_wstrb), .wvalid_i(s_axil_wvalid),
    .wready_o(s_axil_wready), .bresp_o(s_axil_bresp), .bvalid_o(s_axil_bvalid),
    .bready_i(s_axil_bready), .araddr_i(s_axil_araddr), .arvalid_i(s_axil_arvalid),
    .arready_o(s_axil_arready), .rdata_o(s_axil_rdata), .rresp_o(s_axil_rresp),
    .rvalid_o(s_axil_rvalid), .rready_i(s_axil_rready),
    .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data), .wr_strb_o(wr_strb),
    .wr_err_i(wr_err), .rd_en_o(rd_en_unused), .rd_addr_o(rd_addr),
    .rd_data_i(rd_data), .rd_err_i(rd_err)
  );

  logic          start_q, start_d, irq_q, irq_d;
  logic [3:1]    status_q, status_d, irq_en_q, irq_en_d, st_w1c;
  logic [31:0]   run_count_q, run_count_d;
  logic [DW-1:0] data_size_q, data_size_d;
  logic [GW-1:0] grid_size_q, grid_size_d;
  logic [SW-1:0] scle_size_q, scle_size_d;
  logic [63:0]   d64, g64, s64;
  logic [7:0]    wa, ra;
  logic          wr_mapped, size_addr, wr_ok, start_req, start_ok;

  assign wa  = 8'({wr_addr[AXIL_ADDR_WIDTH-1:2], 2'b00});
  assign ra  = 8'({rd_addr[AXIL_ADDR_WIDTH-1:2], 2'b00});
  assign d64 = 64'(data_size_q);
  assign g64 = 64'(grid_size_q);
  assign s64 = 64'(scle_size_q);

  always_comb begin
    wr_mapped = 1'b1;
    size_addr = 1'b0;
    case (wa)
      CSR_CTRL, CSR_STATUS, CSR_IRQ_EN, CSR_RUN_COUNT: ;
      CSR_DATA_LO, CSR_DATA_HI, CSR_GRID_LO, CSR_GRID_HI,
      CSR_SCLE_LO, CSR_SCLE_HI: size_addr = 1'b1;
      default: wr_mapped = 1'b0;
    endcase
  end

  assign wr_err    = !wr_mapped || (size_addr && operation_busy);
  assign wr_ok     = wr_en && !wr_err;
  assign start_req = wr_ok && (wa == CSR_CTRL) && wr_strb[0] && wr_data[0];
  assign start_ok  = start_req && !operation_busy &&
                     (|data_size_q) && (|grid_size_q) && (|scle_size_q);
  assign st_w1c    = (wr_ok && (wa == CSR_STATUS) && wr_strb[0]) ? wr_data[3:1] : 3'b000;

  always_comb begin
    start_d     = start_ok;
    // Sets are ORed in after the clear, so a same-cycle event beats W1C.
    status_d    = (status_q & ~st_w1c) |
                  {start_req && !start_ok, operation_error, operation_complete};
    irq_en_d    = irq_en_q;
    run_count_d = run_count_q + 32'(operation_complete);
    irq_d       = |(status_q & irq_en_q);
    data_size_d = data_size_q;
    grid_size_d = grid_size_q;
    scle_size_d = scle_size_q;
    if (wr_ok) begin
      case (wa)
        CSR_IRQ_EN:               if (wr_strb[0]) irq_en_d = wr_data[3:1];
        CSR_DATA_LO, CSR_DATA_HI: data_size_d = DW'(merge_half(d64, wa[2], wr_data, wr_strb));
        CSR_GRID_LO, CSR_GRID_HI: grid_size_d = GW'(merge_half(g64, wa[2], wr_data, wr_strb));
        CSR_SCLE_LO, CSR_SCLE_HI: scle_size_d = SW'(merge_half(s64, wa[2], wr_data, wr_strb));
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    case (ra)
      CSR_CTRL: ;
      CSR_STATUS: begin
        rd_data[ST_BUSY]           = operation_busy;
        rd_data[ST_REJECT:ST_DONE] = status_q;
      end
      CSR_IRQ_EN:    rd_data[3:1] = irq_en_q;
      CSR_DATA_LO:   rd_data = d64[31:0];
      CSR_DATA_HI:   rd_data = d64[63:32];
      CSR_GRID_LO:   rd_data = g64[31:0];
      CSR_GRID_HI:   rd_data = g64[63:32];
      CSR_SCLE_LO:   rd_data = s64[31:0];
      CSR_SCLE_HI:   rd_data = s64[63:32];
      CSR_RUN_COUNT: rd_data = run_count_q;
      default:       rd_err  = 1'b1;
    endcase
  end

  always_ff @(posedge fsm_clk or posedge rst) begin
    if (rst) begin
      start_q     <= 1'b0;
      irq_q       <= 1'b0;
      status_q    <= '0;
      irq_en_q    <= '0;
      run_count_q <= '0;
      data_size_q <= '0;
      grid_size_q <= '0;
      scle_size_q <= '0;
    end else begin
      start_q     <= start_d;
      irq_q       <= irq_d;
      status_q    <= status_d;
      irq_en_q    <= irq_en_d;
      run_count_q <= run_count_d;
      data_size_q <= data_size_d;
      grid_size_q <= grid_size_d;
      scle_size_q <= scle_size_d;
    end
  end

  assign operation_start = start_q;
  assign irq             = irq_q;
  assign data_size       = data_size_q;
  assign grid_size       = grid_size_q;
  assign scle_size       = scle_size_q;

  logic unused;
  assign unused = ^{s_axil_awprot, s_axil_arprot, wr_addr[1:0], rd_addr[1:0], rd_en_unused};

endmodule

`default_nettype wire

// File: tb/tb_mcu_csr_axil.sv
//------------------------------------------------------------------------------
// tb_mcu_csr_axil -- scoreboard bench for mcu_csr_axil against a register-level model
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mcu_csr_axil;

  logic        fsm_clk = 1'b0, rst = 1'b1;
  logic [5:0]  s_axil_awaddr = '0, s_axil_araddr = '0;
  logic [2:0]  s_axil_awprot = '0, s_axil_arprot = '0;
  logic        s_axil_awvalid = 1'b0, s_axil_wvalid = 1'b0, s_axil_bready = 1'b0;
  logic        s_axil_arvalid = 1'b0, s_axil_rready = 1'b0;
  logic [31:0] s_axil_wdata = '0;
  logic [3:0]  s_axil_wstrb = '0;
  logic        operation_busy = 1'b0, operation_complete = 1'b0, operation_error = 1'b0;
  logic        s_axil_awready, s_axil_wready, s_axil_bvalid, s_axil_arready, s_axil_rvalid;
  logic [1:0]  s_axil_bresp, s_axil_rresp;
  logic [31:0] s_axil_rdata;
  logic        operation_start, irq;
  logic [32:0] data_size, grid_size, scle_size;

  mcu_csr_axil dut (
    .fsm_clk(fsm_clk), .rst(rst),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot),
    .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
    .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
    .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
    .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
    .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
    .operation_start(operation_start), .data_size(data_size), .grid_size(grid_size),
    .scle_size(scle_size), .operation_busy(operation_busy),
    .operation_complete(operation_complete), .operation_error(operation_error), .irq(irq)
  );

  always #5 fsm_clk = ~fsm_clk;

  int checks = 0, failures = 0, start_cnt = 0, exp_starts = 0;

  // Reference model state: register contents as the host would see them.
  logic [63:0] m_size[3];
  logic [63:0] m_mask = (64'd1 << 33) - 64'd1;
  logic        m_done, m_err, m_rej;
  logic [2:0]  m_irq_en;
  logic [31:0] m_run;
  logic [1:0]  bq[$];
  logic [33:0] rq[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    failures++;
    $display("FAIL %s_timeout actual=no_handshake expected=handshake", nm);
  endtask

  function automatic void m_reset();
    for (int i = 0; i < 3; i++) m_size[i] = '0;
    m_done = 0; m_err = 0; m_rej = 0; m_irq_en = '0; m_run = '0;
  endfunction

  function automatic logic [1:0] m_write(input logic [7:0] a, input logic [31:0] d,
                                         input logic [3:0] s);
    int idx;
    if (a inside {8'h10, 8'h14, 8'h18, 8'h1C, 8'h20, 8'h24}) begin
      if (operation_busy) return 2'b10;
      idx = (int'(a) - 16) / 8;
      for (int b = 0; b < 4; b++)
        if (s[b]) m_size[idx][(a[2] ? 32 : 0) + 8*b +: 8] = d[8*b +: 8];
      m_size[idx] = m_size[idx] & m_mask;
      return 2'b00;
    end
    case (a)
      8'h00: if (s[0] && d[0]) begin
        if (!operation_busy && m_size[0] != 0 && m_size[1] != 0 && m_size[2] != 0)
          exp_starts++;
        else
          m_rej = 1;
      end
      8'h04: if (s[0]) begin
        if (d[1]) m_done = 0;
        if (d[2]) m_err = 0;
        if (d[3]) m_rej = 0;
      end
      8'h08: if (s[0]) m_irq_en = d[3:1];
      8'h28: ;
      default: return 2'b10;
    endcase
    return 2'b00;
  endfunction

  function automatic logic [33:0] m_read(input logic [7:0] a);
    logic [31:0] d;
    int idx;
    d = '0;
    if (a inside {8'h10, 8'h14, 8'h18, 8'h1C, 8'h20, 8'h24}) begin
      idx = (int'(a) - 16) / 8;
      d = a[2] ? m_size[idx][63:32] : m_size[idx][31:0];
      return {2'b00, d};
    end
    case (a)
      8'h00: ;
      8'h04: d = {28'd0, m_rej, m_err, m_done, operation_busy};
      8'h08: d = {28'd0, m_irq_en, 1'b0};
      8'h28: d = m_run;
      default: return {2'b10, 32'd0};
    endcase
    return {2'b00, d};
  endfunction

  // Monitor: pops the scoreboard whenever a response handshake is presented.
  always @(negedge fsm_clk) begin
    if (operation_start) start_cnt++;
    if (s_axil_bvalid && s_axil_bready) begin
      if (bq.size() == 0) chk("b_unexpected", 1, 0);
      else chk("bresp", s_axil_bresp, bq.pop_front());
    end
    if (s_axil_rvalid && s_axil_rready) begin
      if (rq.size() == 0) chk("r_unexpected", 1, 0);
      else begin
        logic [33:0] e;
        e = rq.pop_front();
        chk("rdata", s_axil_rdata, e[31:0]);
        chk("rresp", s_axil_rresp, e[33:32]);
      end
    end
  end

  task automatic b_phase(input int dly);
    int n;
    bit hs;
    repeat (dly) begin
      @(negedge fsm_clk);
      chk("no_accept_while_bvalid", {s_axil_awready, s_axil_wready}, 0);
      @(posedge fsm_clk); #1;
    end
    s_axil_bready = 1; n = 0; hs = 0;
    while (!hs && n < 40) begin
      @(negedge fsm_clk); hs = s_axil_bvalid; @(posedge fsm_clk); #1; n++;
    end
    if (!hs) timeout("b");
    s_axil_bready = 0;
  endtask

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int b_dly);
    bq.push_back(m_write(a, d, s));
    fork
      begin
        int n; bit hs;
        repeat (aw_dly) begin
          @(negedge fsm_clk); chk("bvalid_early", s_axil_bvalid, 0); @(posedge fsm_clk); #1;
        end
        s_axil_awaddr = a[5:0]; s_axil_awvalid = 1; n = 0; hs = 0;
        while (!hs && n < 40) begin
          @(negedge fsm_clk); hs = s_axil_awready; @(posedge fsm_clk); #1; n++;
        end
        if (!hs) timeout("aw");
        s_axil_awvalid = 0;
      end
      begin
        int n; bit hs;
        repeat (w_dly) begin
          @(negedge fsm_clk); chk("bvalid_early", s_axil_bvalid, 0); @(posedge fsm_clk); #1;
        end
        s_axil_wdata = d; s_axil_wstrb = s; s_axil_wvalid = 1; n = 0; hs = 0;
        while (!hs && n < 40) begin
          @(negedge fsm_clk); hs = s_axil_wready; @(posedge fsm_clk); #1; n++;
        end
        if (!hs) timeout("w");
        s_axil_wvalid = 0;
      end
    join
    @(negedge fsm_clk);
    chk("bvalid_latency", s_axil_bvalid, 1);
    @(posedge fsm_clk); #1;
    b_phase(b_dly);
    @(posedge fsm_clk); #1;
  endtask

  task automatic axi_read(input logic [7:0] a, input int r_dly);
    int n;
    bit hs;
    rq.push_back(m_read(a));
    s_axil_araddr = a[5:0]; s_axil_arvalid = 1; n = 0; hs = 0;
    while (!hs && n < 40) begin
      @(negedge fsm_clk); hs = s_axil_arready; @(posedge fsm_clk); #1; n++;
    end
    if (!hs) timeout("ar");
    s_axil_arvalid = 0;
    @(negedge fsm_clk);
    chk("rvalid_latency", s_axil_rvalid, 1);
    @(posedge fsm_clk); #1;
    repeat (r_dly) begin @(posedge fsm_clk); #1; end
    s_axil_rready = 1; n = 0; hs = 0;
    while (!hs && n < 40) begin
      @(negedge fsm_clk); hs = s_axil_rvalid; @(posedge fsm_clk); #1; n++;
    end
    if (!hs) timeout("r");
    s_axil_rready = 0;
  endtask

  task automatic pulse(input bit is_err);
    if (is_err) operation_error = 1; else operation_complete = 1;
    @(posedge fsm_clk); #1;
    operation_error = 0; operation_complete = 0;
    if (is_err) m_err = 1;
    else begin m_done = 1; m_run++; end
    @(posedge fsm_clk); #1;
  endtask

  task automatic post_checks();
    @(negedge fsm_clk);
    chk("irq", irq, |({m_rej, m_err, m_done} & m_irq_en));
    chk("data_size", data_size, m_size[0]);
    chk("grid_size", grid_size, m_size[1]);
    chk("scle_size", scle_size, m_size[2]);
    chk("start_pulses", start_cnt, exp_starts);
    @(posedge fsm_clk); #1;
  endtask

  logic [7:0] addrs[13] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18,
                            8'h1C, 8'h20, 8'h24, 8'h28, 8'h2C, 8'h3C};

  initial begin
    m_reset();
    repeat (3) @(negedge fsm_clk);
    chk("rst_ctrl_outs", {operation_start, irq, s_axil_bvalid, s_axil_rvalid,
                          s_axil_awready, s_axil_wready, s_axil_arready}, 0);
    chk("rst_sizes", {data_size, grid_size, scle_size}, 0);
    @(posedge fsm_clk); #1; rst = 0;
    @(posedge fsm_clk); #1;

    axi_read(8'h04, 0);
    axi_write(8'h10, 32'h100, 4'hF, 0, 0, 0);
    axi_write(8'h18, 32'h8,   4'hF, 0, 0, 0);
    axi_write(8'h20, 32'h1,   4'hF, 0, 0, 0);
    axi_write(8'h00, 32'h1,   4'hF, 0, 0, 0);
    post_checks();

    axi_write(8'h20, 32'h0, 4'hF, 0, 0, 0);
    axi_write(8'h00, 32'h1, 4'h1, 0, 0, 0);
    axi_read(8'h04, 0);
    axi_write(8'h04, 32'h8, 4'h1, 0, 0, 0);
    axi_read(8'h04, 0);
    axi_write(8'h20, 32'h1, 4'hF, 0, 0, 0);
    operation_busy = 1;
    axi_write(8'h00, 32'h1, 4'h1, 0, 0, 0);
    axi_read(8'h04, 1);
    axi_write(8'h10, 32'h55, 4'hF, 0, 0, 0);
    axi_read(8'h10, 0);
    operation_busy = 0;
    axi_write(8'h04, 32'hE, 4'h1, 0, 0, 0);
    post_checks();

    axi_write(8'h08, 32'h2, 4'h1, 0, 0, 0);
    operation_complete = 1;
    @(posedge fsm_clk); #1;
    operation_complete = 0; m_done = 1; m_run++;
    @(negedge fsm_clk); chk("irq_not_yet", irq, 0);
    @(negedge fsm_clk); chk("irq_one_later", irq, 1);
    @(posedge fsm_clk); #1;
    axi_read(8'h28, 0);

    // W1C of done executes in the same cycle as a completion pulse.
    bq.push_back(m_write(8'h04, 32'h2, 4'hF));
    m_done = 1; m_run++;
    s_axil_awaddr = 6'h04; s_axil_awvalid = 1;
    s_axil_wdata = 32'h2; s_axil_wstrb = 4'hF; s_axil_wvalid = 1;
    operation_complete = 1;
    @(posedge fsm_clk); #1;
    s_axil_awvalid = 0; s_axil_wvalid = 0; operation_complete = 0;
    b_phase(0);
    @(posedge fsm_clk); #1;
    axi_read(8'h04, 0);
    axi_read(8'h28, 0);
    post_checks();

    axi_write(8'h14, 32'hFFFF_FFFF, 4'hF, 0, 3, 2);
    axi_read(8'h14, 0);
    axi_read(8'h3C, 0);
    post_checks();

    for (int i = 0; i < 200; i++) begin
      int k;
      k = $urandom_range(0, 9);
      if (k <= 3)
        axi_write(addrs[$urandom_range(0, 12)], $urandom, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      else if (k <= 6)
        axi_read(addrs[$urandom_range(0, 12)], $urandom_range(0, 2));
      else if (k == 7)
        pulse(1'($urandom_range(0, 1)));
      else if (k == 8) begin
        operation_busy = 1'($urandom_range(0, 1));
        @(posedge fsm_clk); #1;
      end else
        axi_write(8'h00, 32'h1, 4'h1, 0, 0, $urandom_range(0, 1));
      post_checks();
    end

    // Reset while an AW is parked in the holding slot: it must be discarded.
    operation_busy = 0;
    s_axil_awaddr = 6'h10; s_axil_awvalid = 1;
    @(posedge fsm_clk); #1;
    s_axil_awvalid = 0;
    rst = 1; #1;
    chk("midrst_outs", {s_axil_awready, s_axil_wready, s_axil_arready,
                        s_axil_bvalid, s_axil_rvalid, irq}, 0);
    @(posedge fsm_clk); #1;
    @(posedge fsm_clk); #1;
    rst = 0; m_reset();
    @(posedge fsm_clk); #1;
    axi_write(8'h18, 32'h5, 4'hF, 1, 0, 0);
    axi_read(8'h10, 0);
    axi_read(8'h18, 0);
    axi_read(8'h04, 0);
    post_checks();

    repeat (2) @(posedge fsm_clk);
    chk("bq_drained", bq.size(), 0);
    chk("rq_drained", rq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
